// File: rtl/iob_map_reader_pkg.sv
// Shared defaults, FSM encoding and read-latency constant for the feature-map read engine.
package iob_map_reader_pkg;

    localparam int unsigned ADDR_W_DEF     = 13;
    localparam int unsigned LANES_DEF      = 8;
    localparam int unsigned DW_DEF         = 8;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam int unsigned RD_LAT         = 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDrain = 2'd2,
        StFin   = 2'd3
    } state_e;

endpackage

// File: rtl/iob_rd_fifo.sv
// Small synchronous FIFO with occupancy count; head word is driven straight from the storage array.
module iob_rd_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign w_pop   = i_pop && !o_empty;
    // Gate the head so an empty FIFO (including right after reset) presents zeros.
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/iob_map_reader.sv
// Read-side engine of the ping-pong feature-map buffer: issues a linear read burst and streams
// the returned words to Input_Regfile through a credit-protected output FIFO.
module iob_map_reader
    import iob_map_reader_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned LANES      = LANES_DEF,
    parameter int unsigned DW         = DW_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                  clk_cal,
    input  logic                  rst_cal,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W-1:0]     burst_len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     rd_addr,
    output logic                  Mem_Data_Ivld,
    input  logic                  IOB_Data_O_vld,
    input  logic [LANES*DW-1:0]   IOB_Data_O,
    output logic [LANES*DW-1:0]   out_data,
    output logic                  out_vld,
    input  logic                  out_rdy
);

    localparam int unsigned DATA_W = LANES * DW;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SUM_W  = CNT_W + 2;

    state_e              r_state;
    state_e              w_state_d;
    logic                r_mem_vld;
    logic [RD_LAT-1:0]   r_lat;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [ADDR_W-1:0]   r_next_addr;
    logic [ADDR_W-1:0]   r_remaining;
    logic [ADDR_W-1:0]   r_pop_left;
    logic [ADDR_W-1:0]   w_issue_addr;
    logic [CNT_W-1:0]    w_count;
    logic [SUM_W-1:0]    w_used;
    logic                w_issue;
    logic                w_push;
    logic                w_pop;
    logic                w_empty;
    logic                w_credit;

    assign rd_addr       = r_rd_addr;
    assign Mem_Data_Ivld = r_mem_vld;
    assign out_vld       = !w_empty;
    assign w_pop         = out_vld && out_rdy;
    // Only returns that line up with an earlier strobe are accepted.
    assign w_push        = IOB_Data_O_vld && r_lat[RD_LAT-1];
    assign w_issue_addr  = (r_state == StIdle) ? base_addr : r_next_addr;

    // Words held plus every read already committed (strobe register and return pipeline).
    assign w_used   = SUM_W'(w_count) + SUM_W'(r_mem_vld) + SUM_W'($countones(r_lat));
    assign w_credit = (w_used < SUM_W'(FIFO_DEPTH));

    always_ff @(posedge clk_cal or posedge rst_cal) begin
        if (rst_cal) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_issue   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    if (burst_len != '0) begin
                        w_issue   = 1'b1;
                        w_state_d = (burst_len == ADDR_W'(1)) ? StDrain : StIssue;
                    end else begin
                        // Empty burst passes one busy cycle in DRAIN before the done pulse.
                        w_state_d = StDrain;
                    end
                end
            end
            StIssue: begin
                if (w_credit) begin
                    w_issue = 1'b1;
                    if (r_remaining == ADDR_W'(1)) begin
                        w_state_d = StFin == StFin ? StDrain : StDrain;
                    end
                end
            end
            StDrain: begin
                // The last pop implies FIFO empty and nothing in flight.
                if ((r_pop_left == '0) || (w_pop && (r_pop_left == ADDR_W'(1)))) begin
                    w_state_d = StFin;
                end
            end
            StFin: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (r_state)
            StIssue, StDrain: busy = 1'b1;
            StFin:            done = 1'b1;
            default:          ;
        endcase
    end

    always_ff @(posedge clk_cal or posedge rst_cal) begin
        if (rst_cal) begin
            r_mem_vld   <= 1'b0;
            r_lat       <= '0;
            r_rd_addr   <= '0;
            r_next_addr <= '0;
            r_remaining <= '0;
            r_pop_left  <= '0;
        end else begin
            r_mem_vld <= w_issue;
            r_lat     <= RD_LAT'({r_lat, r_mem_vld});
            if (w_issue) begin
                r_rd_addr   <= w_issue_addr;
                r_next_addr <= w_issue_addr + ADDR_W'(1);
            end
            if (r_state == StIdle) begin
                if (start) begin
                    r_remaining <= burst_len - ADDR_W'(1);
                    r_pop_left  <= burst_len;
                end
            end else begin
                if (w_issue) begin
                    r_remaining <= r_remaining - ADDR_W'(1);
                end
                if (w_pop) begin
                    r_pop_left <= r_pop_left - ADDR_W'(1);
                end
            end
        end
    end

    iob_rd_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .i_clk   (clk_cal),
        .i_rst   (rst_cal),
        .i_push  (w_push),
        .i_data  (IOB_Data_O),
        .i_pop   (w_pop),
        .o_data  (out_data),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    ap_no_stray_return: assert property (@(posedge clk_cal) disable iff (rst_cal)
        IOB_Data_O_vld |-> r_lat[RD_LAT-1]);

    ap_no_overflow: assert property (@(posedge clk_cal) disable iff (rst_cal)
        !(w_push && !w_pop && (w_count == CNT_W'(FIFO_DEPTH))));

endmodule
